tft_spi_decoder: RTL and testbench
==================================

# tft_spi_decoder

Receive-side decoder for the 4-wire TFT SPI link driven by `tft_spi`. It passively samples SCK/MOSI/DC/CS and reassembles bytes. It then interprets the ILI9341-style command stream: CASET 0x2A, PASET 0x2B and RAMWR 0x2C, producing one strobe per RGB565 pixel with its screen coordinate. It sits on the analyzer tap next to the display, for in-system checking of scene/player drawing and for simulation scoreboarding.

## Interface

Parameters:
- `SYNC_STAGES`, 2: flip-flop stages on each SPI input before edge detection (minimum 2).
- `COORD_W`, 9: width of coordinate outputs; 16-bit window parameters are truncated to the low `COORD_W` bits.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: reset, synchronous, active-low.
- `spi_clk` in 1: SPI SCK, mode 0.
- `spi_mosi` in 1: SPI data, MSB first.
- `spi_dc` in 1: 0 = command, 1 = data; sampled with bit 0 of each byte.
- `spi_cs` in 1: chip select, active-low; may be tied 0.
- `byte_valid` out 1: one-cycle strobe, byte complete.
- `byte_data` out 8: last received byte.
- `byte_dc` out 1: DC captured with that byte.
- `pix_valid` out 1: one-cycle strobe, pixel complete.
- `pix_x`, `pix_y` out COORD_W: coordinate of the pixel.
- `pix_color` out 16: RGB565, first byte is the high byte.
- `win_x0`, `win_x1`, `win_y0`, `win_y1` out COORD_W: current address window.
- `unk_cmd` out 1: one-cycle strobe, command byte not in {0x2A, 0x2B, 0x2C}.

## Operation

Input stage:
- All four SPI inputs pass through `SYNC_STAGES` synchronizer stages.
- A rising edge of synchronized SCK while CS=0 shifts MOSI into an 8-bit shift register and increments a 3-bit bit counter.
- On the 8th bit, `byte_data`, `byte_dc` and `byte_valid` are registered and the bit counter returns to 0.
- CS=1 clears the bit counter and discards any partial byte. FSM state is retained.

Decoder FSM (advances only on `byte_valid`):
- CMD: waiting for a command.
- Any byte with dc=0, in any state, is decoded as a new command:
  - 0x2A → CASET_P with param count 0.
  - 0x2B → PASET_P with param count 0.
  - 0x2C → RAMWR; sets cur_x=`win_x0`, cur_y=`win_y0`, phase=HI.
  - Anything else → SKIP and pulses `unk_cmd`.
- CASET_P / PASET_P:
  - Collect 4 data bytes p0..p3.
  - On p3, commit window0={p0,p1} and window1={p2,p3} (truncated) atomically.
  - Further data bytes are ignored; the FSM stays put.
  - A new command before p3 leaves the window unchanged.
- RAMWR, phase HI: latch the byte as the colour high byte, then go to phase LO.
- RAMWR, phase LO:
  - Emit a pixel at (cur_x, cur_y), then return to phase HI.
  - Advance: if cur_x==`win_x1`, set cur_x=`win_x0` and cur_y = (cur_y==`win_y1`) ? `win_y0` : cur_y+1; otherwise cur_x+1.
  - Wrap comparisons use equality only. If x0>x1, the counter runs modulo 2^COORD_W until it reaches x1; the same applies to y.
  - A dangling HI byte at the next command is dropped without a pixel.
- SKIP: data bytes are ignored.
- Data bytes received in CMD are ignored.

Reset values:
- All strobes 0; `byte_data`=0, `byte_dc`=0, `pix_*`=0.
- Window: x0=0, x1=239, y0=0, y1=319.
- FSM in CMD; bit counter 0.
- Reset is honoured mid-byte and mid-pixel and discards all partial state.

## Timing

- SCK high and low phases must each be ≥2 `clk` cycles. Faster SCK is unsupported and may drop bits.
- `byte_valid` asserts `SYNC_STAGES`+2 cycles after the `clk` edge that first sees the 8th SCK rise on the raw pin.
- `pix_valid` and window updates occur 1 cycle after the `byte_valid` of the completing byte.
- `pix_x`/`pix_y`/`pix_color` are stable from `pix_valid` until the next `pix_valid`.
- No backpressure: every strobe is one cycle and unbuffered.

## Configuration

- `TFT_SPI_DECODER_STATS_EN` defined: adds outputs `cmd_count` (16 bits, counts dc=0 bytes) and `pix_count` (24 bits, counts `pix_valid`). Both counters saturate at all-ones and reset to 0.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

## Test plan

- Send 0x2A, 00 0A 00 0B, then 0x2B, 00 14 00 15 → window registers read (10, 11, 20, 21), 0 `pix_valid`.
- After that, send 0x2C plus 10 bytes 0xF800×5 → pixels at (10,20), (11,20), (10,21), (11,21), (10,20), each colour 0xF800.
- Send 0x2A, 00 05 00 → then 0x2C → window unchanged (0/239); RAMWR starts at (0,0).
- Send 0x2C, 0x12, then 0x29 → no pixel; `unk_cmd` pulse; a following 0x2C plus AB CD → pixel at `win_x0`,`win_y0` with colour 0xABCD.
- Send 4 bits, then CS high, then byte 0x2C with dc=0 → exactly one `byte_valid`, with data 0x2C.
- Assert `rst` mid-RAMWR after a HI byte → all outputs at reset values; the next LO-phase byte is not emitted as a pixel. With the stats macro defined, the counters read 0.

Source files
------------

// File: rtl/tft_spi_decoder.sv
// tft_spi_decoder: passive 4-wire TFT SPI receiver decoding CASET/PASET/RAMWR into pixel strobes.
// Define TFT_SPI_DECODER_STATS_EN to add saturating cmd_count/pix_count outputs.
module tft_spi_decoder #(
  parameter int SYNC_STAGES = 2,
  parameter int COORD_W     = 9
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               spi_clk,
  input  logic               spi_mosi,
  input  logic               spi_dc,
  input  logic               spi_cs,
  output logic               byte_valid,
  output logic [7:0]         byte_data,
  output logic               byte_dc,
  output logic               pix_valid,
  output logic [COORD_W-1:0] pix_x,
  output logic [COORD_W-1:0] pix_y,
  output logic [15:0]        pix_color,
  output logic [COORD_W-1:0] win_x0,
  output logic [COORD_W-1:0] win_x1,
  output logic [COORD_W-1:0] win_y0,
  output logic [COORD_W-1:0] win_y1,
  output logic               unk_cmd
`ifdef TFT_SPI_DECODER_STATS_EN
  ,
  output logic [15:0]        cmd_count,
  output logic [23:0]        pix_count
`endif
);
  typedef enum logic [2:0] {S_CMD, S_CASET, S_PASET, S_RAMWR, S_SKIP} state_t;
  logic [SYNC_STAGES-1:0] r_sck_s, r_mosi_s, r_dc_s, r_cs_s;
  logic w_sck, w_mosi, w_dc, w_cs;
  logic r_sck_d, r_rise, r_cs_hi, r_mosi, r_dc, r_done, r_done_dc;
  logic [7:0] r_shift;
  logic [2:0] r_bcnt;
  state_t r_state, w_next;
  logic [2:0] r_pcnt;
  logic [23:0] r_p;
  logic [7:0] r_hi;
  logic r_lo;
  logic [COORD_W-1:0] r_cur_x, r_cur_y, w_p01, w_p23;
  logic w_cmd, w_param, w_hi, w_pix;
  assign w_sck  = r_sck_s[SYNC_STAGES-1];
  assign w_mosi = r_mosi_s[SYNC_STAGES-1];
  assign w_dc   = r_dc_s[SYNC_STAGES-1];
  assign w_cs   = r_cs_s[SYNC_STAGES-1];
  assign w_p01  = COORD_W'(r_p[23:8]);
  assign w_p23  = COORD_W'({r_p[7:0], byte_data});
  // Edge detect is registered along with MOSI/DC so data and strobe stay aligned.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sck_s    <= '0;
      r_mosi_s   <= '0;
      r_dc_s     <= '0;
      r_cs_s     <= '1;
      r_sck_d    <= 1'b0;
      r_rise     <= 1'b0;
      r_cs_hi    <= 1'b1;
      r_mosi     <= 1'b0;
      r_dc       <= 1'b0;
      r_shift    <= '0;
      r_bcnt     <= '0;
      r_done     <= 1'b0;
      r_done_dc  <= 1'b0;
      byte_valid <= 1'b0;
      byte_data  <= '0;
      byte_dc    <= 1'b0;
    end else begin
      r_sck_s    <= {r_sck_s[SYNC_STAGES-2:0], spi_clk};
      r_mosi_s   <= {r_mosi_s[SYNC_STAGES-2:0], spi_mosi};
      r_dc_s     <= {r_dc_s[SYNC_STAGES-2:0], spi_dc};
      r_cs_s     <= {r_cs_s[SYNC_STAGES-2:0], spi_cs};
      r_sck_d    <= w_sck;
      r_rise     <= w_sck & ~r_sck_d & ~w_cs;
      r_cs_hi    <= w_cs;
      r_mosi     <= w_mosi;
      r_dc       <= w_dc;
      r_done     <= 1'b0;
      if (r_cs_hi)
        r_bcnt <= '0;
      else if (r_rise) begin
        r_shift   <= {r_shift[6:0], r_mosi};
        r_bcnt    <= r_bcnt + 1'b1;
        r_done    <= (r_bcnt == 3'd7);
        r_done_dc <= r_dc;
      end
      byte_valid <= r_done;
      if (r_done) begin
        byte_data <= r_shift;
        byte_dc   <= r_done_dc;
      end
    end
  end
  always_ff @(posedge clk) r_state <= !rst ? S_CMD : w_next;
  always_comb begin
    w_next = r_state;
    if (byte_valid && !byte_dc)
      w_next = byte_data == 8'h2A ? S_CASET :
               byte_data == 8'h2B ? S_PASET :
               byte_data == 8'h2C ? S_RAMWR : S_SKIP;
  end
  always_comb begin
    w_cmd   = byte_valid & ~byte_dc;
    w_param = byte_valid & byte_dc & (r_state == S_CASET || r_state == S_PASET) & (r_pcnt != 3'd4);
    w_hi    = byte_valid & byte_dc & (r_state == S_RAMWR) & ~r_lo;
    w_pix   = byte_valid & byte_dc & (r_state == S_RAMWR) & r_lo;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      pix_valid <= 1'b0;
      pix_x     <= '0;
      pix_y     <= '0;
      pix_color <= '0;
      win_x0    <= '0;
      win_x1    <= COORD_W'(239);
      win_y0    <= '0;
      win_y1    <= COORD_W'(319);
      unk_cmd   <= 1'b0;
      r_pcnt    <= '0;
      r_p       <= '0;
      r_hi      <= '0;
      r_lo      <= 1'b0;
      r_cur_x   <= '0;
      r_cur_y   <= '0;
    end else begin
      pix_valid <= 1'b0;
      unk_cmd   <= w_cmd & (w_next == S_SKIP);
      if (w_cmd) begin
        r_pcnt  <= '0;
        r_lo    <= 1'b0;
        r_cur_x <= win_x0;
        r_cur_y <= win_y0;
      end
      if (w_param) begin
        r_pcnt <= r_pcnt + 1'b1;
        r_p    <= {r_p[15:0], byte_data};
      end
      if (w_param && r_pcnt == 3'd3 && r_state == S_CASET) begin
        win_x0 <= w_p01;
        win_x1 <= w_p23;
      end
      if (w_param && r_pcnt == 3'd3 && r_state == S_PASET) begin
        win_y0 <= w_p01;
        win_y1 <= w_p23;
      end
      if (w_hi) begin
        r_hi <= byte_data;
        r_lo <= 1'b1;
      end
      // Wrap tests are equality only, so an inverted window runs modulo 2^COORD_W.
      if (w_pix) begin
        r_lo      <= 1'b0;
        pix_valid <= 1'b1;
        pix_x     <= r_cur_x;
        pix_y     <= r_cur_y;
        pix_color <= {r_hi, byte_data};
        r_cur_x   <= (r_cur_x == win_x1) ? win_x0 : r_cur_x + 1'b1;
        if (r_cur_x == win_x1)
          r_cur_y <= (r_cur_y == win_y1) ? win_y0 : r_cur_y + 1'b1;
      end
    end
  end
`ifdef TFT_SPI_DECODER_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      cmd_count <= '0;
      pix_count <= '0;
    end else begin
      if (w_cmd && cmd_count != '1)
        cmd_count <= cmd_count + 1'b1;
      if (pix_valid && pix_count != '1)
        pix_count <= pix_count + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_tft_spi_decoder.sv
// tb_tft_spi_decoder: randomized SPI command streams checked against a behavioural display model.
module tb_tft_spi_decoder;
  localparam int SS   = 2;
  localparam int CW   = 9;
  localparam int CMAX = 1 << CW;
  typedef struct {int x; int y; int c;} pix_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic spi_clk = 1'b0, spi_mosi = 1'b0, spi_dc = 1'b0, spi_cs = 1'b0;
  logic byte_valid, byte_dc, pix_valid, unk_cmd;
  logic [7:0] byte_data;
  logic [15:0] pix_color;
  logic [CW-1:0] pix_x, pix_y, win_x0, win_x1, win_y0, win_y1;
`ifdef TFT_SPI_DECODER_STATS_EN
  logic [15:0] cmd_count;
  logic [23:0] pix_count;
`endif
  tft_spi_decoder #(.SYNC_STAGES(SS), .COORD_W(CW)) dut (
    .clk(clk), .rst(rst), .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_dc(spi_dc), .spi_cs(spi_cs),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_dc(byte_dc),
    .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_color(pix_color),
    .win_x0(win_x0), .win_x1(win_x1), .win_y0(win_y0), .win_y1(win_y1), .unk_cmd(unk_cmd)
`ifdef TFT_SPI_DECODER_STATS_EN
    , .cmd_count(cmd_count), .pix_count(pix_count)
`endif
  );
  always #5 clk = ~clk;
  int n_checks = 0, n_fail = 0;
  int cyc = 0, rise_cyc = 0;
  bit settled = 1'b1;
  int exp_bytes[$];
  pix_t exp_pix[$], pix_log[$];
  int n_bytes_seen = 0, last_byte = 0, unk_seen = 0, pix_seen = 0;
  int last_x = 0, last_y = 0, last_c = 0;
  int m_mode = -1, m_pc = 0, m_hi = 0, m_cx = 0, m_cy = 0, m_unk = 0, m_cmds = 0, m_pixels = 0;
  bit m_hp = 1'b0;
  int m_p[4];
  int m_wx0 = 0, m_wx1 = 239, m_wy0 = 0, m_wy1 = 319;
  function automatic void chk(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
    end
  endfunction
  // Display model: what an ILI9341 would do with the byte, straight from the command semantics.
  function automatic void model_byte(bit dc, int d);
    pix_t p;
    int a, b;
    exp_bytes.push_back(dc * 256 + d);
    if (!dc) begin
      m_cmds++;
      m_mode = (d == 'h2A || d == 'h2B || d == 'h2C) ? d : 0;
      if (m_mode == 0) m_unk++;
      m_pc = 0;
      m_hp = 1'b0;
      m_cx = m_wx0;
      m_cy = m_wy0;
    end else if ((m_mode == 'h2A || m_mode == 'h2B) && m_pc < 4) begin
      m_p[m_pc] = d;
      m_pc++;
      if (m_pc == 4) begin
        a = (m_p[0] * 256 + m_p[1]) % CMAX;
        b = (m_p[2] * 256 + m_p[3]) % CMAX;
        if (m_mode == 'h2A) begin m_wx0 = a; m_wx1 = b; end
        else begin m_wy0 = a; m_wy1 = b; end
      end
    end else if (m_mode == 'h2C) begin
      if (!m_hp) begin
        m_hi = d;
        m_hp = 1'b1;
      end else begin
        p.x = m_cx; p.y = m_cy; p.c = m_hi * 256 + d;
        exp_pix.push_back(p);
        m_pixels++;
        m_hp = 1'b0;
        if (m_cx == m_wx1) begin
          m_cx = m_wx0;
          m_cy = (m_cy == m_wy1) ? m_wy0 : (m_cy + 1) % CMAX;
        end else
          m_cx = (m_cx + 1) % CMAX;
      end
    end
  endfunction
  function automatic void model_reset();
    exp_bytes.delete();
    exp_pix.delete();
    m_mode = -1; m_pc = 0; m_hp = 1'b0; m_cmds = 0; m_pixels = 0;
    m_wx0 = 0; m_wx1 = 239; m_wy0 = 0; m_wy1 = 319;
    last_x = 0; last_y = 0; last_c = 0;
  endfunction
  always @(posedge clk) cyc <= cyc + 1;
  always begin
    @(posedge clk);
    #1;
    if (rst) begin
      if (byte_valid) begin
        n_bytes_seen++;
        last_byte = byte_data;
        chk("byte_latency", cyc - rise_cyc - 1, SS + 2);
        if (exp_bytes.size() == 0) chk("byte_unexpected", exp_bytes.size(), 1);
        else chk("byte", {byte_dc, byte_data}, exp_bytes.pop_front());
      end
      if (pix_valid) begin
        pix_t e, g;
        pix_seen++;
        g.x = pix_x; g.y = pix_y; g.c = pix_color;
        pix_log.push_back(g);
        if (exp_pix.size() == 0) chk("pix_unexpected", exp_pix.size(), 1);
        else begin
          e = exp_pix.pop_front();
          last_x = e.x; last_y = e.y; last_c = e.c;
        end
      end
      chk("pix_x", pix_x, last_x);
      chk("pix_y", pix_y, last_y);
      chk("pix_color", pix_color, last_c);
      if (unk_cmd) unk_seen++;
      if (settled) begin
        chk("win_x0", win_x0, m_wx0);
        chk("win_x1", win_x1, m_wx1);
        chk("win_y0", win_y0, m_wy0);
        chk("win_y1", win_y1, m_wy1);
`ifdef TFT_SPI_DECODER_STATS_EN
        chk("cmd_count", cmd_count, m_cmds);
        chk("pix_count", pix_count, m_pixels);
`endif
      end
    end
  end
  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic send_bits(input logic [7:0] d, input int nbits);
    for (int i = 7; i > 7 - nbits; i--) begin
      spi_mosi = d[i];
      wait_clk(3);
      spi_clk = 1'b1;
      if (i == 0) rise_cyc = cyc;
      wait_clk(3);
      spi_clk = 1'b0;
    end
  endtask
  task automatic send_byte(input bit dc, input logic [7:0] d);
    settled = 1'b0;
    model_byte(dc, int'(d));
    spi_dc = dc;
    send_bits(d, 8);
    wait_clk(5);
    settled = 1'b1;
  endtask
  task automatic check_reset_outputs(input string tag);
    chk({tag, "_byte_valid"}, byte_valid, 0);
    chk({tag, "_byte_data"}, byte_data, 0);
    chk({tag, "_byte_dc"}, byte_dc, 0);
    chk({tag, "_pix_valid"}, pix_valid, 0);
    chk({tag, "_pix_x"}, pix_x, 0);
    chk({tag, "_pix_y"}, pix_y, 0);
    chk({tag, "_pix_color"}, pix_color, 0);
    chk({tag, "_unk"}, unk_cmd, 0);
    chk({tag, "_win_x0"}, win_x0, 0);
    chk({tag, "_win_x1"}, win_x1, 239);
    chk({tag, "_win_y0"}, win_y0, 0);
    chk({tag, "_win_y1"}, win_y1, 319);
`ifdef TFT_SPI_DECODER_STATS_EN
    chk({tag, "_cmd_count"}, cmd_count, 0);
    chk({tag, "_pix_count"}, pix_count, 0);
`endif
  endtask
  task automatic do_reset();
    rst = 1'b0;
    model_reset();
    wait_clk(3);
    check_reset_outputs("reset");
    rst = 1'b1;
    wait_clk(2);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end
  initial begin
    int ex_x[5] = '{10, 11, 10, 11, 10};
    int ex_y[5] = '{20, 20, 21, 21, 20};
    int base, n, c, k, v, w;
    logic [7:0] prm[4];
    do_reset();
    // Window programming and a 2x2 RAMWR that wraps back to the origin.
    send_byte(0, 8'h2A); send_byte(1, 8'h00); send_byte(1, 8'h0A); send_byte(1, 8'h00); send_byte(1, 8'h0B);
    send_byte(0, 8'h2B); send_byte(1, 8'h00); send_byte(1, 8'h14); send_byte(1, 8'h00); send_byte(1, 8'h15);
    chk("t1_win_x0", win_x0, 10);
    chk("t1_win_x1", win_x1, 11);
    chk("t1_win_y0", win_y0, 20);
    chk("t1_win_y1", win_y1, 21);
    chk("t1_no_pix", pix_seen, 0);
    pix_log.delete();
    send_byte(0, 8'h2C);
    for (int i = 0; i < 5; i++) begin send_byte(1, 8'hF8); send_byte(1, 8'h00); end
    chk("t2_pix_count", pix_log.size(), 5);
    for (int i = 0; i < 5; i++)
      if (i < pix_log.size()) begin
        chk("t2_x", pix_log[i].x, ex_x[i]);
        chk("t2_y", pix_log[i].y, ex_y[i]);
        chk("t2_color", pix_log[i].c, 'hF800);
      end
    // Truncated CASET leaves the default window in place.
    do_reset();
    send_byte(0, 8'h2A); send_byte(1, 8'h00); send_byte(1, 8'h05); send_byte(1, 8'h00);
    pix_log.delete();
    send_byte(0, 8'h2C); send_byte(1, 8'h12); send_byte(1, 8'h34);
    chk("t3_win_x0", win_x0, 0);
    chk("t3_win_x1", win_x1, 239);
    chk("t3_pix_n", pix_log.size(), 1);
    if (pix_log.size() > 0) begin
      chk("t3_x", pix_log[0].x, 0);
      chk("t3_y", pix_log[0].y, 0);
    end
    // Dangling HI byte is dropped by an unknown command.
    base = unk_seen;
    pix_log.delete();
    send_byte(0, 8'h2C); send_byte(1, 8'h12); send_byte(0, 8'h29);
    chk("t4_no_pix", pix_log.size(), 0);
    chk("t4_unk", unk_seen - base, 1);
    send_byte(0, 8'h2C); send_byte(1, 8'hAB); send_byte(1, 8'hCD);
    chk("t4_pix_n", pix_log.size(), 1);
    if (pix_log.size() > 0) begin
      chk("t4_x", pix_log[0].x, 0);
      chk("t4_y", pix_log[0].y, 0);
      chk("t4_color", pix_log[0].c, 'hABCD);
    end
    // Partial byte aborted by CS.
    base = n_bytes_seen;
    settled = 1'b0;
    send_bits(8'hA5, 4);
    wait_clk(3);
    spi_cs = 1'b1;
    wait_clk(6);
    spi_cs = 1'b0;
    wait_clk(3);
    send_byte(0, 8'h2C);
    chk("t5_bytes", n_bytes_seen - base, 1);
    chk("t5_data", last_byte, 'h2C);
    // Inverted window: x runs 510,511,0,1 before wrapping.
    send_byte(0, 8'h2A); send_byte(1, 8'h01); send_byte(1, 8'hFE); send_byte(1, 8'h00); send_byte(1, 8'h01);
    pix_log.delete();
    send_byte(0, 8'h2C);
    for (int i = 0; i < 5; i++) begin send_byte(1, 8'h07); send_byte(1, 8'hE0); end
    chk("t6_pix_n", pix_log.size(), 5);
    if (pix_log.size() == 5) begin
      chk("t6_x0", pix_log[0].x, 510);
      chk("t6_x2", pix_log[2].x, 0);
      chk("t6_x4", pix_log[4].x, 510);
      chk("t6_y4", pix_log[4].y, 1);
    end
    // Randomized command streams.
    for (int t = 0; t < 60; t++) begin
      k = $urandom_range(0, 5);
      if (k <= 1) begin
        send_byte(0, k == 0 ? 8'h2A : 8'h2B);
        n = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 6) : 4;
        v = $urandom_range(0, 40);
        w = $urandom_range(0, 3);
        prm[0] = 8'($urandom_range(0, 2));
        prm[1] = 8'(v);
        prm[2] = ($urandom_range(0, 4) == 0) ? 8'($urandom) : prm[0];
        prm[3] = 8'(v + w);
        for (int i = 0; i < n; i++) send_byte(1, i < 4 ? prm[i] : 8'($urandom));
      end else if (k == 2) begin
        send_byte(0, 8'h2C);
        n = $urandom_range(0, 17);
        for (int i = 0; i < n; i++) send_byte(1, 8'($urandom));
      end else if (k == 3) begin
        do c = $urandom_range(0, 255); while (c >= 'h2A && c <= 'h2C);
        send_byte(0, 8'(c));
        n = $urandom_range(0, 2);
        for (int i = 0; i < n; i++) send_byte(1, 8'($urandom));
      end else if (k == 4) begin
        n = $urandom_range(1, 3);
        for (int i = 0; i < n; i++) send_byte(1, 8'($urandom));
      end else begin
        send_byte(0, 8'h2C);
        n = 2 * $urandom_range(1, 6);
        for (int i = 0; i < n; i++) send_byte(1, 8'($urandom));
      end
    end
    chk("rand_unk_total", unk_seen, m_unk);
    // Reset in the middle of a RAMWR pixel and in the middle of a byte.
    send_byte(0, 8'h2C);
    send_byte(1, 8'h55);
    settled = 1'b0;
    send_bits(8'hFF, 3);
    base = pix_seen;
    do_reset();
    settled = 1'b1;
    send_byte(1, 8'h66);
    chk("t7_no_pix", pix_seen - base, 0);
    pix_log.delete();
    send_byte(0, 8'h2C); send_byte(1, 8'h12); send_byte(1, 8'h34);
    chk("t7_pix_n", pix_log.size(), 1);
    if (pix_log.size() > 0) chk("t7_color", pix_log[0].c, 'h1234);
    wait_clk(10);
    chk("bytes_left", exp_bytes.size(), 0);
    chk("pix_left", exp_pix.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
